fbuf_write_arbiter: RTL
=======================

// Module: fbuf_write_arbiter
// PURPOSE
//  Owns the single write port of the 64x64 panel framebuffer (4096 x 4-bit pixels; addr MSB = panel half).
//  Shares it between a CPU pixel-write stream (valid/ready) and a built-in fill engine that paints the whole
//  buffer one colour. Sits between the CPU bus bridge and framebuffer.waddr/we/din.
//  The read side, driven by LED_controller, is untouched.
// PARAMETERS
//  ADDR_W     12  framebuffer address width (4096 pixels)
//  DATA_W     4   pixel width
//  CPU_BURST  4   max consecutive CPU grants while a fill is pending before the fill engine is forced a slot
// PORTS
//  clk         in   1       system clock
//  rst         in   1       asynchronous, active-low reset
//  cpu_valid   in   1       CPU write request
//  cpu_ready   out  1       CPU request accepted this cycle (combinational)
//  cpu_addr    in   ADDR_W  CPU pixel address
//  cpu_data    in   DATA_W  CPU pixel value
//  fill_start  in   1       one-cycle pulse: start fill
//  fill_color  in   DATA_W  fill colour, sampled with fill_start
//  fill_busy   out  1       fill in progress
//  fill_done   out  1       one-cycle pulse: fill finished
//  fb_we       out  1       framebuffer write enable (registered)
//  fb_waddr    out  ADDR_W  framebuffer write address (registered)
//  fb_din      out  DATA_W  framebuffer write data (registered)
// BEHAVIOUR
//  - Reset (rst=0, async): state IDLE; fb_we=0, fb_waddr=0, fb_din=0; fill_busy=0, fill_done=0.
//    Fill counter, latched colour and streak counter = 0. A fill in progress is abandoned; no done pulse.
//  - FSM IDLE -> FILL on fill_start. FILL -> IDLE in the cycle after the grant with fill_ptr==4095.
//    fill_done pulses in that same cycle, and fill_busy drops with it.
//  - fill_start in FILL is ignored; fill_color is not re-sampled.
//  - Grant, each cycle:
//      IDLE: cpu_ready=1; handshake = cpu_valid.
//      FILL: the CPU wins if cpu_valid && streak<CPU_BURST, and streak increments.
//            Otherwise the fill engine wins: it writes fill_ptr, fill_ptr increments, streak clears.
//            cpu_ready=0 only when streak==CPU_BURST; that forced slot goes to the fill.
//      If cpu_valid=0 in FILL, the fill always wins.
//  - Latency: a grant at edge N puts the write on fb_* after edge N, where it is seen at edge N+1.
//    Exactly one write per grant; fb_we=0 in any cycle with no grant.
//  - fill_start and cpu_valid in the same IDLE cycle: the CPU write is granted.
//    The FSM enters FILL with fill_ptr=0, and the first fill write happens no earlier than the next cycle.
//  - Fill throughput is >= 1 write per CPU_BURST+1 cycles, so a fill completes within 4096*(CPU_BURST+1) cycles.
//  - Ordering: a CPU write to an address the fill has not yet reached is later overwritten by the fill.
//    Software waits for fill_done before drawing; the arbiter does not detect this hazard.
//  - fill_ptr is ADDR_W bits and stops at 4095; it does not wrap. streak saturates at CPU_BURST.
// STRUCTURE
//  - Shared package fbuf_pkg:
//      localparam FB_ADDR_W=12, FB_DATA_W=4, PANEL_ROWS=32, PANEL_COLS=64
//      typedef fb_addr_t, fb_pix_t
//      typedef enum {ARB_IDLE, ARB_FILL} arb_state_e
//  - Single module, no sub-modules. Grant logic is a combinational block; state, counters and fb_* outputs
//    are registered in one always_ff with async active-low reset.
// TESTING
//  1. Reset: hold rst=0 for 3 cycles with cpu_valid=1
//     -> fb_we=0, fill_busy=0, cpu_ready stays 1 (IDLE), and no write happens until rst=1.
//  2. CPU only: write addr 0x000=5, 0x7FF=A, 0xFFF=F back-to-back
//     -> fb_we high for 3 cycles, one cycle after each handshake, with matching addr/data.
//  3. Fill alone: fill_start with colour 3, no CPU traffic
//     -> 4096 writes, addr 0..4095, all data 3; fill_done pulses once, 4097 cycles after start; fill_busy low after.
//  4. Contention: fill in progress and cpu_valid held high (CPU_BURST=4)
//     -> pattern of 4 CPU writes then 1 fill write; cpu_ready low exactly on the forced cycle; fill completes.
//  5. Simultaneous start: fill_start with cpu_valid (addr 0x123) in IDLE
//     -> the CPU write 0x123 appears first; the fill's first write (addr 0) follows; a second fill_start mid-fill is ignored.
//  6. Reset mid-fill: assert rst at fill_ptr=1000
//     -> fb_we drops asynchronously, no fill_done, IDLE; the next fill_start restarts at addr 0.

Source files
------------

// File: rtl/fbuf_pkg.sv
// Shared framebuffer types and geometry for the 64x64 panel (two 32-row halves).
package fbuf_pkg;

  localparam int FB_ADDR_W  = 12;
  localparam int FB_DATA_W  = 4;
  localparam int PANEL_ROWS = 32;
  localparam int PANEL_COLS = 64;

  typedef logic [FB_ADDR_W-1:0] fb_addr_t;
  typedef logic [FB_DATA_W-1:0] fb_pix_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_FILL = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fbuf_write_arbiter.sv
// Framebuffer write-port arbiter: CPU pixel stream vs. whole-buffer colour fill.
// state    | meaning
// ARB_IDLE | CPU owns the port, always ready
// ARB_FILL | fill running; CPU gets at most CPU_BURST slots between fill writes
module fbuf_write_arbiter
  import fbuf_pkg::*;
#(
  parameter int ADDR_W    = FB_ADDR_W,
  parameter int DATA_W    = FB_DATA_W,
  parameter int CPU_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_color,
  output logic              fill_busy,
  output logic              fill_done,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_waddr,
  output logic [DATA_W-1:0] fb_din
);

  localparam int                 STREAK_W  = $clog2(CPU_BURST + 1);
  localparam logic [STREAK_W-1:0] BURST_MAX = STREAK_W'(CPU_BURST);
  localparam logic [ADDR_W-1:0]   PTR_LAST  = {ADDR_W{1'b1}};

  arb_state_e          state_q, state_d;
  logic [ADDR_W-1:0]   fill_ptr_q, fill_ptr_d;
  logic [DATA_W-1:0]   color_q, color_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                done_q, done_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic                cpu_gnt, fill_gnt;

  always_comb begin
    state_d    = state_q;
    fill_ptr_d = fill_ptr_q;
    color_d    = color_q;
    streak_d   = streak_q;
    done_d     = 1'b0;
    cpu_ready  = 1'b1;
    cpu_gnt    = 1'b0;
    fill_gnt   = 1'b0;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    din_d      = din_q;

    case (state_q)
      ARB_IDLE: begin
        cpu_gnt  = cpu_valid;
        streak_d = '0;
        // A simultaneous CPU request is still served; the fill starts next cycle.
        if (fill_start) begin
          state_d    = ARB_FILL;
          fill_ptr_d = '0;
          color_d    = fill_color;
        end
      end
      ARB_FILL: begin
        cpu_ready = (streak_q != BURST_MAX);
        cpu_gnt   = cpu_valid && (streak_q < BURST_MAX);
        fill_gnt  = !cpu_gnt;
        if (cpu_gnt) begin
          streak_d = streak_q + 1'b1;
        end
        if (fill_gnt) begin
          streak_d = '0;
          if (fill_ptr_q == PTR_LAST) begin
            state_d = ARB_IDLE;
            done_d  = 1'b1;
          end else begin
            fill_ptr_d = fill_ptr_q + 1'b1;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    if (cpu_gnt) begin
      we_d    = 1'b1;
      waddr_d = cpu_addr;
      din_d   = cpu_data;
    end else if (fill_gnt) begin
      we_d    = 1'b1;
      waddr_d = fill_ptr_q;
      din_d   = color_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ARB_IDLE;
      fill_ptr_q <= '0;
      color_q    <= '0;
      streak_q   <= '0;
      done_q     <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      din_q      <= '0;
    end else begin
      state_q    <= state_d;
      fill_ptr_q <= fill_ptr_d;
      color_q    <= color_d;
      streak_q   <= streak_d;
      done_q     <= done_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      din_q      <= din_d;
    end
  end

  assign fill_busy = (state_q == ARB_FILL);
  assign fill_done = done_q;
  assign fb_we     = we_q;
  assign fb_waddr  = waddr_q;
  assign fb_din    = din_q;

endmodule
